afu_irq_responder: RTL and testbench
====================================

# afu_irq_responder

FIM-side responder for AFU interrupt requests. Each AFU port raises requests tagged with a local vector (0..NUM_AFU_INTERRUPTS-1). The block latches them into a pending bitmap, coalescing duplicates, and selects one round-robin. It forwards the selection to the MSI-X table as a flat index, waits for the table's write-completion ack, then returns a one-cycle ack with the vector to the originating AFU. It sits between the port/AFU interrupt interfaces and the MSI-X table logic; one interrupt is in flight at a time.

## Interface
- NUM_AFUS, default ofs_fim_cfg_pkg::NUM_AFUS (1): number of AFU request ports.
- NUM_IRQ, default ofs_fim_cfg_pkg::NUM_AFU_INTERRUPTS (7): vectors per AFU.
- VEC_W, default ofs_fim_cfg_pkg::L_NUM_AFU_INTERRUPTS (3): AFU-local vector width.
- IDX_W, default $clog2(NUM_AFUS*NUM_IRQ): flat MSI-X index width.
- ACK_TIMEOUT, default 1024: cycles to wait for msix_ack before abandoning.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- afu_irq_valid  in  NUM_AFUS  per-AFU request strobe.
- afu_irq_vec  in  NUM_AFUS*VEC_W  per-AFU vector; AFU i uses bits [i*VEC_W +: VEC_W].
- afu_irq_ready  out  NUM_AFUS  request accepted when valid&&ready.
- afu_ack_valid  out  NUM_AFUS  one-hot, one-cycle completion pulse.
- afu_ack_vec  out  VEC_W  vector being acked (shared by all ports).
- msix_req_valid  out  1  request to MSI-X table.
- msix_req_ready  in  1  table accepts.
- msix_req_idx  out  IDX_W  flat index = afu*NUM_IRQ + vec.
- msix_ack  in  1  pulse: table write for in-flight request completed.
- pending  out  NUM_AFUS*NUM_IRQ  pending bitmap, flat index order.
- err_vec_range  out  1  sticky: a vector >= NUM_IRQ was received.
- err_timeout  out  1  sticky: ACK_TIMEOUT expired.

## Operation
- Reset values: all outputs 0; pending 0; RR pointer 0; state IDLE; timeout counter 0.
- afu_irq_ready is a register: 0 in reset, 1 from the first cycle after rst deasserts. All requests are accepted because the bitmap coalesces.
- On accept, a vector < NUM_IRQ sets pending[afu*NUM_IRQ+vec]. A request for a bit already set is absorbed silently. A vector >= NUM_IRQ is dropped and sets err_vec_range.
- FSM:
  - IDLE: if pending != 0, pick the first set bit at or after the RR pointer, with wrap-around. Clear that bit, latch it as in-flight, set pointer = winner+1 (mod NUM_AFUS*NUM_IRQ), go to ISSUE.
  - ISSUE: msix_req_valid=1 with the in-flight idx. On msix_req_ready, drop valid and go to WAIT. valid/idx hold stable until accepted.
  - WAIT: count cycles. On msix_ack, go to RESP. When the count reaches ACK_TIMEOUT-1 with no ack, set err_timeout and return to IDLE; no AFU ack is sent.
  - RESP: afu_ack_valid[in-flight afu]=1 and afu_ack_vec=in-flight vec for exactly one cycle, then IDLE.
- Set and clear of the same bit in one cycle (new request while IDLE selects it): the set wins, the bit stays pending, and a second interrupt follows.
- A request for the in-flight bit during ISSUE/WAIT/RESP re-sets pending and is delivered again later.
- msix_ack outside WAIT is ignored.
- Simultaneous requests from several AFUs are all captured in the same cycle.
- rst mid-operation returns everything to reset values. The in-flight request and pending bits are lost, and no ack is issued.

## Timing
- Request accepted at cycle T: pending bit visible T+1, IDLE selects at T+1, msix_req_valid high T+2 (pending and idle).
- If msix_req_ready is high at T+2: WAIT from T+3.
- msix_ack at cycle A: afu_ack_valid high A+1, IDLE at A+2, next msix_req_valid no earlier than A+3.
- Minimum request-to-request spacing on the MSI-X side: 4 cycles.
- Timeout fires at WAIT entry + ACK_TIMEOUT cycles.

## Structure
- ofs_fim_cfg_pkg supplies NUM_AFUS, NUM_AFU_INTERRUPTS and L_NUM_AFU_INTERRUPTS.
- Add to ofs_fim_cfg_pkg:
  - MSIX_AFU_IDX_W = $clog2(NUM_AFUS*NUM_AFU_INTERRUPTS).
  - MSIX_ACK_TIMEOUT.
  - typedef enum for the FSM state (IDLE, ISSUE, WAIT, RESP).
- One sub-module: irq_rr_arbiter (parameterized width; inputs request vector and pointer; outputs winner index and found flag; combinational).

## Test plan
- NUM_AFUS=1: vec 5 at T, msix_req_ready tied 1, msix_ack 3 cycles after issue -> msix_req_idx=5 at T+2; afu_ack_valid=1, afu_ack_vec=5 one cycle after ack; pending returns to 0.
- Vec 2 requested three times while vec 2 is pending (not yet selected) -> exactly one MSI-X request and one ack.
- NUM_AFUS=2: AFU0 vec 6 and AFU1 vec 0 in the same cycle, pointer 0 -> idx 6 issued first, then idx 7. The AFU1 ack carries afu_ack_vec=0.
- Vec 7 received with NUM_IRQ=7 -> dropped, err_vec_range=1, pending unchanged, no MSI-X request.
- ACK_TIMEOUT=16, msix_ack never arrives -> err_timeout=1 sixteen cycles after WAIT entry, no afu_ack_valid, next pending bit is issued.
- rst asserted during WAIT with two bits pending -> next cycle all outputs 0, pending 0. A late msix_ack produces no afu_ack_valid.

Source files
------------

// File: rtl/ofs_fim_cfg_pkg.sv
// FIM configuration constants plus the shared types of the AFU interrupt responder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ofs_fim_cfg_pkg;

    localparam int NUM_AFUS             = 1;
    localparam int NUM_AFU_INTERRUPTS   = 7;
    localparam int L_NUM_AFU_INTERRUPTS = 3;

    // Width of the flat MSI-X index covering every AFU vector.
    localparam int MSIX_AFU_IDX_W   = $clog2(NUM_AFUS * NUM_AFU_INTERRUPTS);
    // Cycles to wait for the MSI-X table write ack before giving up.
    localparam int MSIX_ACK_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_ISSUE = 2'd1,
        IRQ_WAIT  = 2'd2,
        IRQ_RESP  = 2'd3
    } irq_state_e;

endpackage

// File: rtl/irq_rr_arbiter.sv
// Round-robin pick: first set bit of req at or after ptr, wrapping to bit 0.
// Latency: combinational. Backpressure: none.
// Ports: req (request bitmap), ptr (search start), winner (selected index), found (any bit set).
module irq_rr_arbiter #(
    parameter int WIDTH = 7,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    always_comb begin
        int j;
        j      = 0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            // Walk the bitmap starting at ptr; positions past the top wrap to 0.
            j = int'(ptr) + i;
            if (j >= WIDTH) begin
                j = j - WIDTH;
            end
            if (!found && req[j]) begin
                winner = IDX_W'(j);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/afu_irq_responder.sv
// AFU interrupt responder: coalesce per-AFU vectors into a pending bitmap, forward one at a
// time round-robin to the MSI-X table, and return a one-cycle ack to the requesting AFU.
// Latency: request at T -> msix_req_valid at T+2; msix_ack at A -> afu_ack_valid at A+1.
// Backpressure: none toward AFUs (bitmap absorbs duplicates); msix_req_valid/idx hold until msix_req_ready.
// Ports: clk/rst (sync active-high); afu_irq_* request side; afu_ack_* completion side;
//        msix_req_* / msix_ack table side; pending bitmap and sticky error flags.
module afu_irq_responder
    import ofs_fim_cfg_pkg::*;
#(
    parameter int NUM_AFUS    = ofs_fim_cfg_pkg::NUM_AFUS,
    parameter int NUM_IRQ     = ofs_fim_cfg_pkg::NUM_AFU_INTERRUPTS,
    parameter int VEC_W       = ofs_fim_cfg_pkg::L_NUM_AFU_INTERRUPTS,
    parameter int IDX_W       = $clog2(NUM_AFUS * NUM_IRQ),
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_AFUS-1:0]         afu_irq_valid,
    input  logic [NUM_AFUS*VEC_W-1:0]   afu_irq_vec,
    output logic [NUM_AFUS-1:0]         afu_irq_ready,
    output logic [NUM_AFUS-1:0]         afu_ack_valid,
    output logic [VEC_W-1:0]            afu_ack_vec,
    output logic                        msix_req_valid,
    input  logic                        msix_req_ready,
    output logic [IDX_W-1:0]            msix_req_idx,
    input  logic                        msix_ack,
    output logic [NUM_AFUS*NUM_IRQ-1:0] pending,
    output logic                        err_vec_range,
    output logic                        err_timeout
);

    localparam int N     = NUM_AFUS * NUM_IRQ;
    localparam int AFU_W = (NUM_AFUS > 1) ? $clog2(NUM_AFUS) : 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

    irq_state_e          state_q, state_d;
    logic [N-1:0]        pending_q, pending_d;
    logic [N-1:0]        set_bits, clr_bits;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [AFU_W-1:0]    afu_q, afu_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rdy_q;
    logic                err_range_q, err_range_d;
    logic                err_to_q, err_to_d;
    logic                range_hit;
    logic [IDX_W-1:0]    win;
    logic                found;

    irq_rr_arbiter #(
        .WIDTH (N),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (pending_q),
        .ptr    (ptr_q),
        .winner (win),
        .found  (found)
    );

    // Request capture: every AFU can land a vector in the same cycle.
    always_comb begin
        set_bits  = '0;
        range_hit = 1'b0;
        for (int a = 0; a < NUM_AFUS; a++) begin
            if (afu_irq_valid[a] && rdy_q) begin
                if (int'(afu_irq_vec[a*VEC_W +: VEC_W]) < NUM_IRQ) begin
                    set_bits[a*NUM_IRQ + int'(afu_irq_vec[a*VEC_W +: VEC_W])] = 1'b1;
                end else begin
                    range_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        idx_d          = idx_q;
        afu_d          = afu_q;
        vec_d          = vec_q;
        cnt_d          = cnt_q;
        clr_bits       = '0;
        err_to_d       = err_to_q;
        msix_req_valid = 1'b0;
        afu_ack_valid  = '0;
        case (state_q)
            IRQ_IDLE: begin
                if (found) begin
                    clr_bits[win] = 1'b1;
                    idx_d         = win;
                    // Split the flat index back into (afu, local vector).
                    for (int a = 0; a < NUM_AFUS; a++) begin
                        if (int'(win) >= a * NUM_IRQ) begin
                            afu_d = AFU_W'(a);
                            vec_d = VEC_W'(int'(win) - a * NUM_IRQ);
                        end
                    end
                    ptr_d   = (int'(win) == N - 1) ? '0 : win + IDX_W'(1);
                    state_d = IRQ_ISSUE;
                end
            end
            IRQ_ISSUE: begin
                msix_req_valid = 1'b1;
                if (msix_req_ready) begin
                    cnt_d   = '0;
                    state_d = IRQ_WAIT;
                end
            end
            IRQ_WAIT: begin
                if (msix_ack) begin
                    cnt_d   = '0;
                    state_d = IRQ_RESP;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    // Abandon the interrupt: no AFU ack is sent.
                    err_to_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = IRQ_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IRQ_RESP: begin
                afu_ack_valid[afu_q] = 1'b1;
                state_d              = IRQ_IDLE;
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    // A new request for the bit being selected this cycle wins over the clear.
    assign pending_d   = (pending_q & ~clr_bits) | set_bits;
    assign err_range_d = err_range_q | range_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IRQ_IDLE;
            pending_q   <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
            afu_q       <= '0;
            vec_q       <= '0;
            cnt_q       <= '0;
            rdy_q       <= 1'b0;
            err_range_q <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            afu_q       <= afu_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            rdy_q       <= 1'b1;
            err_range_q <= err_range_d;
            err_to_q    <= err_to_d;
        end
    end

    assign afu_irq_ready = {NUM_AFUS{rdy_q}};
    assign msix_req_idx  = (state_q == IRQ_ISSUE) ? idx_q : '0;
    assign afu_ack_vec   = (state_q == IRQ_RESP)  ? vec_q : '0;
    assign pending       = pending_q;
    assign err_vec_range = err_range_q;
    assign err_timeout   = err_to_q;

endmodule

// File: tb/tb_afu_irq_responder.sv
// Directed bench for afu_irq_responder: two AFUs, seven vectors each, 16-cycle ack timeout.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that point too.
module tb_afu_irq_responder;

    localparam int NA  = 2;
    localparam int NI  = 7;
    localparam int VW  = 3;
    localparam int IW  = 4;
    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NA-1:0]     afu_irq_valid;
    logic [NA*VW-1:0]  afu_irq_vec;
    logic [NA-1:0]     afu_irq_ready;
    logic [NA-1:0]     afu_ack_valid;
    logic [VW-1:0]     afu_ack_vec;
    logic              msix_req_valid;
    logic              msix_req_ready;
    logic [IW-1:0]     msix_req_idx;
    logic              msix_ack;
    logic [NA*NI-1:0]  pending;
    logic              err_vec_range;
    logic              err_timeout;

    int total = 0;
    int bad   = 0;

    afu_irq_responder #(
        .NUM_AFUS    (NA),
        .NUM_IRQ     (NI),
        .VEC_W       (VW),
        .IDX_W       (IW),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .afu_irq_valid  (afu_irq_valid),
        .afu_irq_vec    (afu_irq_vec),
        .afu_irq_ready  (afu_irq_ready),
        .afu_ack_valid  (afu_ack_valid),
        .afu_ack_vec    (afu_ack_vec),
        .msix_req_valid (msix_req_valid),
        .msix_req_ready (msix_req_ready),
        .msix_req_idx   (msix_req_idx),
        .msix_ack       (msix_ack),
        .pending        (pending),
        .err_vec_range  (err_vec_range),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         afu;
        int         vec;
        int         exp_idx;
        logic [1:0] exp_oh;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic req(input int afu, input int vec);
        afu_irq_valid[afu]          = 1'b1;
        afu_irq_vec[afu*VW +: VW]   = VW'(vec);
    endtask

    task automatic req_clear();
        afu_irq_valid = '0;
    endtask

    // Wait (bounded) for an MSI-X request, accept it, ack 3 cycles after issue, check the AFU ack.
    task automatic serve(input string nm, input int exp_idx, input logic [1:0] exp_oh, input int exp_vec);
        int n;
        n = 0;
        while (msix_req_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({nm, "_req_seen"}, msix_req_valid, 1);
        check({nm, "_idx"}, msix_req_idx, exp_idx);
        tick();
        tick();
        tick();
        msix_ack = 1'b1;
        tick();
        msix_ack = 1'b0;
        check({nm, "_ack_oh"}, afu_ack_valid, exp_oh);
        check({nm, "_ack_vec"}, afu_ack_vec, exp_vec);
        tick();
        check({nm, "_ack_one_cycle"}, afu_ack_valid, 0);
    endtask

    initial begin
        int cnt;
        int acks;

        tbl[0] = '{afu: 0, vec: 5, exp_idx: 5,  exp_oh: 2'b01};
        tbl[1] = '{afu: 1, vec: 0, exp_idx: 7,  exp_oh: 2'b10};
        tbl[2] = '{afu: 1, vec: 6, exp_idx: 13, exp_oh: 2'b10};
        tbl[3] = '{afu: 0, vec: 0, exp_idx: 0,  exp_oh: 2'b01};
        tbl[4] = '{afu: 1, vec: 3, exp_idx: 10, exp_oh: 2'b10};
        tbl[5] = '{afu: 0, vec: 6, exp_idx: 6,  exp_oh: 2'b01};

        rst            = 1'b1;
        afu_irq_valid  = '0;
        afu_irq_vec    = '0;
        msix_req_ready = 1'b1;
        msix_ack       = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_ready", afu_irq_ready, 0);
        check("rst_ack_valid", afu_ack_valid, 0);
        check("rst_ack_vec", afu_ack_vec, 0);
        check("rst_req_valid", msix_req_valid, 0);
        check("rst_req_idx", msix_req_idx, 0);
        check("rst_pending", pending, 0);
        check("rst_err_range", err_vec_range, 0);
        check("rst_err_timeout", err_timeout, 0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", afu_irq_ready, 2'b11);

        // Single requests, exact T+1 / T+2 timing.
        for (int i = 0; i < 6; i++) begin
            req(tbl[i].afu, tbl[i].vec);
            tick();
            req_clear();
            check($sformatf("tbl%0d_pending", i), pending, 32'd1 << tbl[i].exp_idx);
            tick();
            check($sformatf("tbl%0d_valid_t2", i), msix_req_valid, 1);
            check($sformatf("tbl%0d_idx_t2", i), msix_req_idx, tbl[i].exp_idx);
            serve($sformatf("tbl%0d", i), tbl[i].exp_idx, tbl[i].exp_oh, tbl[i].vec);
            check($sformatf("tbl%0d_pending_clr", i), pending, 0);
        end

        // Coalescing: vec 2 requested three times while the table stalls vec 4 in ISSUE.
        msix_req_ready = 1'b0;
        req(0, 4);
        tick();
        req_clear();
        tick();
        check("coal_stall_valid", msix_req_valid, 1);
        req(0, 2);
        tick();
        tick();
        msix_ack = 1'b1;
        tick();
        req_clear();
        msix_ack = 1'b0;
        check("coal_pending", pending, 32'h4);
        check("coal_idx_held", msix_req_idx, 4);
        check("coal_valid_held", msix_req_valid, 1);
        check("ack_outside_wait", afu_ack_valid, 0);
        tick();
        check("ack_outside_wait2", afu_ack_valid, 0);
        msix_req_ready = 1'b1;
        serve("coal_first", 4, 2'b01, 4);
        serve("coal_second", 2, 2'b01, 2);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (msix_req_valid === 1'b1) cnt++;
        end
        check("coal_no_extra_req", cnt, 0);

        // Two AFUs in the same cycle, pointer back at 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req(0, 6);
        req(1, 0);
        tick();
        req_clear();
        check("dual_pending", pending, 32'h0C0);
        serve("dual_afu0", 6, 2'b01, 6);
        serve("dual_afu1", 7, 2'b10, 0);

        // Out-of-range vector.
        req(0, 7);
        tick();
        req_clear();
        check("range_err", err_vec_range, 1);
        check("range_pending", pending, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (msix_req_valid === 1'b1) cnt++;
        end
        check("range_no_req", cnt, 0);

        // Ack timeout, then the next pending bit is issued.
        req(0, 1);
        tick();
        req(0, 3);
        tick();
        req_clear();
        cnt = 0;
        while (msix_req_valid !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        check("tmo_idx", msix_req_idx, 1);
        tick();
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (afu_ack_valid !== 2'b00) acks++;
        end
        check("tmo_not_yet", err_timeout, 0);
        tick();
        check("tmo_fired", err_timeout, 1);
        check("tmo_no_ack", acks, 0);
        check("tmo_ack_now", afu_ack_valid, 0);
        serve("tmo_next", 3, 2'b01, 3);
        check("tmo_sticky", err_timeout, 1);

        // Set and clear of the same bit in one cycle: a second interrupt follows.
        req(0, 2);
        tick();
        tick();
        req_clear();
        check("setclr_pending", pending, 32'h4);
        serve("setclr_first", 2, 2'b01, 2);
        serve("setclr_second", 2, 2'b01, 2);
        check("setclr_pending_end", pending, 0);

        // Reset during WAIT with two bits pending.
        req(0, 0);
        tick();
        req(0, 4);
        tick();
        req(0, 5);
        tick();
        req_clear();
        check("rstw_pending", pending, 32'h030);
        check("rstw_in_wait", msix_req_valid, 0);
        rst = 1'b1;
        tick();
        check("rstw_pending0", pending, 0);
        check("rstw_ready0", afu_irq_ready, 0);
        check("rstw_valid0", msix_req_valid, 0);
        check("rstw_ack0", afu_ack_valid, 0);
        check("rstw_errs0", {err_vec_range, err_timeout}, 0);
        rst      = 1'b0;
        msix_ack = 1'b1;
        tick();
        msix_ack = 1'b0;
        acks = 0;
        cnt  = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (afu_ack_valid !== 2'b00) acks++;
            if (msix_req_valid === 1'b1) cnt++;
        end
        check("rstw_late_ack", acks, 0);
        check("rstw_no_req", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
